// File: rtl/rv_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, the
// requester encoding, and the round-robin pick.
package rv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  // A lone request always wins; on a tie the side not granted last wins.
  function automatic owner_t rr_pick(input logic ireq, input logic dreq, input owner_t last);
    if (ireq && dreq) return (last == OWN_I) ? OWN_D : OWN_I;
    return dreq ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/rv_timeout_cnt.sv
// Response-wait watchdog: counts enabled cycles since the last clear and flags
// the cycle whose closing edge brings the count to TIMEOUT_CYC.
module rv_timeout_cnt #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic clk_top,
  input  logic reset_top,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TOP  = CW'(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_top or negedge reset_top) begin
    if (!reset_top)                    count <= '0;
    else if (clear)                    count <= '0;
    else if (enable && count != TOP)   count <= count + CW'(1);
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/rv_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// and data ports, with one outstanding transaction and a response timeout.
module rv_mem_arbiter
  import rv_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                clk_top,
  input  logic                reset_top,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic                i_err,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic                d_err,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata
);

  arb_state_t state;
  owner_t     owner;
  owner_t     last_own;
  owner_t     winner;
  logic       armed;
  logic       grant;
  logic       expired;

  assign winner = rr_pick(i_req, d_req, last_own);
  // armed holds off grants until the first edge after reset release
  assign grant  = armed && (state == IDLE) && (i_req || d_req);

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    i_gnt   = 1'b0;
    d_gnt   = 1'b0;
    m_req   = grant;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_be    = '0;
    if (grant) begin
      if (winner == OWN_D) begin
        d_gnt   = 1'b1;
        m_we    = d_we;
        m_addr  = d_addr;
        m_wdata = d_wdata;
        m_be    = d_be;
      end else begin
        i_gnt   = 1'b1;
        m_addr  = i_addr;
        m_be    = '1;
      end
    end
  end

  rv_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk_top   (clk_top),
    .reset_top (reset_top),
    .clear     (grant),
    .enable    (state == BUSY),
    .expired   (expired)
  );

  always_ff @(posedge clk_top or negedge reset_top) begin
    if (!reset_top) begin
      state    <= IDLE;
      owner    <= OWN_I;
      last_own <= OWN_I;  // "fetch went last" so data wins the first tie
      armed    <= 1'b0;
      i_rvalid <= 1'b0;
      i_err    <= 1'b0;
      i_rdata  <= '0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      d_rdata  <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (grant) begin
            owner    <= winner;
            last_own <= winner;
            state    <= BUSY;
          end
        end
        BUSY: begin
          // A real ack beats a timeout firing in the same cycle.
          if (m_rvalid || expired) begin
            state <= RESP;
            if (owner == OWN_D) begin
              d_rvalid <= 1'b1;
              d_err    <= !m_rvalid;
              d_rdata  <= m_rvalid ? m_rdata : '0;
            end else begin
              i_rvalid <= 1'b1;
              i_err    <= !m_rvalid;
              i_rdata  <= m_rvalid ? m_rdata : '0;
            end
          end
        end
        RESP: begin
          state    <= IDLE;
          i_rvalid <= 1'b0;
          i_err    <= 1'b0;
          d_rvalid <= 1'b0;
          d_err    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Self-checking bench for rv_mem_arbiter: directed transaction table, reset
// sequences, and randomized traffic against a transaction-level model.
module tb_rv_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int T      = 15;
  localparam int NEVER  = 1000;  // memory latency meaning "no ack at all"

  // One transaction; lat = cycles between memory capturing the request and
  // its ack, so m_rvalid lands lat+1 cycles after the grant.
  typedef struct {
    logic        i_req;
    logic        d_req;
    logic        d_we;
    logic [31:0] i_addr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    int          lat;
    logic [31:0] rdata;
    logic        exp_d;
    int          exp_cyc;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } txn_t;

  logic              clk_top = 1'b0;
  logic              reset_top;
  logic              i_req, i_gnt, i_rvalid, i_err;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic [3:0]        d_be;
  logic              m_req, m_we, m_rvalid;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;
  logic [3:0]        m_be;

  int   total = 0;
  int   bad   = 0;
  logic last_was_d;
  txn_t tbl [11];

  always #5 clk_top = ~clk_top;

  rv_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(T)) dut (
    .clk_top(clk_top), .reset_top(reset_top),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_top);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, m_req, m_we}, 0);
    check({tag, "_i_rdata"}, i_rdata, 0);
    check({tag, "_d_rdata"}, d_rdata, 0);
    check({tag, "_m_addr"}, m_addr, 0);
    check({tag, "_m_wdata"}, m_wdata, 0);
    check({tag, "_m_be"}, m_be, 0);
  endtask

  function automatic txn_t mk(input logic ir, input logic dr, input logic we,
                              input logic [31:0] ia, input logic [31:0] da,
                              input logic [31:0] wd, input logic [3:0] be, input int lat,
                              input logic [31:0] rd, input logic ed, input int ec,
                              input logic ee, input logic [31:0] erd);
    txn_t t;
    t.i_req = ir;  t.d_req = dr;  t.d_we = we;  t.i_addr = ia;  t.d_addr = da;
    t.d_wdata = wd;  t.d_be = be;  t.lat = lat;  t.rdata = rd;
    t.exp_d = ed;  t.exp_cyc = ec;  t.exp_err = ee;  t.exp_rdata = erd;
    return t;
  endfunction

  // Idle gap (with stray acks), request, grant checks, memory model, response checks.
  task automatic run_txn(input txn_t t, input int gap);
    logic stray_gnt, stray_rv, done;
    int   k;
    stray_rv = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    for (int g = 0; g < gap; g++) begin
      m_rvalid = 1'($urandom_range(0, 1));
      m_rdata  = $urandom;
      @(negedge clk_top);
      if (i_rvalid || d_rvalid || i_gnt || d_gnt) stray_rv = 1'b1;
      next_cycle();
    end
    if (gap > 0) check("idle_quiet", stray_rv, 0);

    m_rvalid = 1'b0;
    m_rdata  = $urandom;
    i_req = t.i_req;  d_req = t.d_req;  d_we = t.d_we;
    i_addr = t.i_addr;  d_addr = t.d_addr;  d_wdata = t.d_wdata;  d_be = t.d_be;
    @(negedge clk_top);
    check("gnt_excl", i_gnt && d_gnt, 0);
    check("gnt_i", i_gnt, !t.exp_d);
    check("gnt_d", d_gnt, t.exp_d);
    check("m_req", m_req, 1);
    check("m_addr", m_addr, t.exp_d ? t.d_addr : t.i_addr);
    check("m_we", m_we, t.exp_d ? t.d_we : 1'b0);
    check("m_be", m_be, t.exp_d ? t.d_be : 4'hF);
    if (t.exp_d && t.d_we) check("m_wdata", m_wdata, t.d_wdata);
    last_was_d = t.exp_d;
    next_cycle();

    if (t.exp_d) d_req = 1'b0;
    else         i_req = 1'b0;
    done = 1'b0;  stray_gnt = 1'b0;  stray_rv = 1'b0;  k = 1;
    while (!done && k <= 40) begin
      m_rvalid = (k == t.lat + 1);
      m_rdata  = m_rvalid ? t.rdata : $urandom;
      @(negedge clk_top);
      if (i_gnt || d_gnt || m_req) stray_gnt = 1'b1;
      if (t.exp_d ? i_rvalid : d_rvalid) stray_rv = 1'b1;
      if (t.exp_d ? d_rvalid : i_rvalid) begin
        done = 1'b1;
        check("resp_cycle", k, t.exp_cyc);
        check("resp_err", t.exp_d ? d_err : i_err, t.exp_err);
        check("resp_rdata", t.exp_d ? d_rdata : i_rdata, t.exp_rdata);
      end
      next_cycle();
      if (!done) k++;
    end
    check("resp_seen", done, 1);
    check("gnt_while_busy", stray_gnt, 0);
    check("other_rvalid", stray_rv, 0);

    i_req = 1'b0;  d_req = 1'b0;  m_rvalid = 1'b0;
    @(negedge clk_top);
    check("rvalid_one_cycle", i_rvalid || d_rvalid, 0);
    next_cycle();
  endtask

  initial begin
    txn_t r;
    int   sel;

    tbl[0]  = mk(1, 0, 0, 32'h10, 32'h0,  32'h0,        4'h0, 1,     32'h00500093, 0, 3,  0, 32'h00500093);
    tbl[1]  = mk(1, 1, 0, 32'h14, 32'h40, 32'h0,        4'hF, 0,     32'h11112222, 1, 2,  0, 32'h11112222);
    tbl[2]  = mk(1, 1, 0, 32'h18, 32'h44, 32'h0,        4'hF, 2,     32'h33334444, 0, 4,  0, 32'h33334444);
    tbl[3]  = mk(1, 1, 1, 32'h1C, 32'h48, 32'h55556666, 4'h3, 3,     32'h77778888, 1, 5,  0, 32'h77778888);
    tbl[4]  = mk(1, 1, 0, 32'h20, 32'h4C, 32'h0,        4'hF, 0,     32'h9999AAAA, 0, 2,  0, 32'h9999AAAA);
    tbl[5]  = mk(0, 1, 1, 32'h0,  32'h20, 32'hDEADBEEF, 4'hF, 1,     32'h0,        1, 3,  0, 32'h0);
    tbl[6]  = mk(0, 1, 0, 32'h0,  32'h24, 32'h0,        4'hF, NEVER, 32'hBAD0BAD0, 1, 16, 1, 32'h0);
    tbl[7]  = mk(1, 0, 0, 32'h30, 32'h0,  32'h0,        4'h0, 14,    32'hCAFEF00D, 0, 16, 0, 32'hCAFEF00D);
    tbl[8]  = mk(1, 0, 0, 32'h34, 32'h0,  32'h0,        4'h0, 15,    32'h0BADF00D, 0, 16, 1, 32'h0);
    tbl[9]  = mk(0, 1, 1, 32'h0,  32'h28, 32'h01020304, 4'h1, 0,     32'hFFFFFFFF, 1, 2,  0, 32'hFFFFFFFF);
    tbl[10] = mk(1, 1, 0, 32'h38, 32'h2C, 32'h0,        4'hF, 5,     32'h5A5A5A5A, 0, 7,  0, 32'h5A5A5A5A);

    // Reset held with every input active: all outputs must stay zero.
    reset_top = 1'b0;
    i_req = 1'b1;  d_req = 1'b1;  d_we = 1'b1;
    i_addr = 32'hA0;  d_addr = 32'hB0;  d_wdata = 32'h12345678;  d_be = 4'hF;
    m_rvalid = 1'b1;  m_rdata = 32'hFFFF0000;
    repeat (3) @(posedge clk_top);
    @(negedge clk_top);
    check_quiet("reset");
    next_cycle();
    reset_top = 1'b1;
    @(negedge clk_top);
    check("gnt_before_first_edge", i_gnt || d_gnt, 0);
    next_cycle();
    last_was_d = 1'b0;

    for (int n = 0; n < 11; n++) run_txn(tbl[n], 1 + n % 3);

    // Reset dropped while BUSY: transaction abandoned, pointer back to data.
    i_req = 1'b0;  d_req = 1'b1;  d_we = 1'b0;  d_addr = 32'h80;  m_rvalid = 1'b0;
    @(negedge clk_top);
    check("pre_reset_gnt", d_gnt, 1);
    next_cycle();
    d_req = 1'b0;
    next_cycle();
    reset_top = 1'b0;
    i_req = 1'b1;  d_req = 1'b1;  m_rvalid = 1'b1;  m_rdata = 32'h00001234;
    #1;
    check_quiet("busy_reset");
    next_cycle();
    next_cycle();
    reset_top = 1'b1;
    @(negedge clk_top);
    check("release_gnt", i_gnt || d_gnt, 0);
    check("release_rvalid", i_rvalid || d_rvalid, 0);
    next_cycle();
    last_was_d = 1'b0;
    run_txn(mk(1, 1, 0, 32'h90, 32'h94, 32'h0, 4'hF, 2, 32'h0F0F0F0F, 1, 4, 0, 32'h0F0F0F0F), 0);

    // Random traffic checked against the transaction-level model.
    for (int n = 0; n < 60; n++) begin
      sel       = int'($urandom_range(1, 3));
      r.i_req   = sel[0];
      r.d_req   = sel[1];
      r.d_we    = 1'($urandom_range(0, 1));
      r.i_addr  = $urandom;
      r.d_addr  = $urandom;
      r.d_wdata = $urandom;
      r.d_be    = 4'($urandom);
      r.lat     = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, T + 2));
      r.rdata   = $urandom;
      r.exp_d   = (r.i_req && r.d_req) ? !last_was_d : r.d_req;
      if (r.lat + 1 <= T) begin
        r.exp_cyc   = r.lat + 2;
        r.exp_err   = 1'b0;
        r.exp_rdata = r.rdata;
      end else begin
        r.exp_cyc   = T + 1;
        r.exp_err   = 1'b1;
        r.exp_rdata = '0;
      end
      run_txn(r, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
